uart_rx_fifo_ctrl: RTL and testbench

UART_RX_FIFO_CTRL -- requirements
Module: uart_rx_fifo_ctrl

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rx_fifo_ctrl_if.sv | 24 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_rx_fifo_ctrl.sv | 51 +++++
 tb/tb_uart_rx_fifo_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared capture-FSM encoding and overflow-mode constants
package uart_pkg;
    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_CLR  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam int OVF_DROP      = 0;
    localparam int OVF_OVERWRITE = 1;
endpackage

// File: rtl/uart_rx_fifo_ctrl_if.sv
// uart_rx_fifo_ctrl_if: receiver-side and consumer-side signals of the RX FIFO controller
interface uart_rx_fifo_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    logic                         rdrf;
    logic [DATA_W-1:0]            rx_data;
    logic                         rdrf_clr;
    logic                         rd_en;
    logic [DATA_W-1:0]            dout;
    logic                         empty;
    logic                         full;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         ovf;
    logic                         ovf_clr;
    modport master (
        output rdrf, rx_data, rd_en, ovf_clr,
        input  rdrf_clr, dout, empty, full, count, ovf
    );
    modport slave (
        input  rdrf, rx_data, rd_en, ovf_clr,
        output rdrf_clr, dout, empty, full, count, ovf
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with registered empty/full/count
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              empty_q, full_q, do_wr, do_rd;
    // a write into a full FIFO is only accepted when the head leaves in the same cycle
    assign do_rd = rd_en && !empty_q;
    assign do_wr = wr_en && (!full_q || do_rd);
    // next pointers and occupancy; flags are derived from the next count so all three stay consistent
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
    end
    // pointer and flag registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= count_d == '0;
            full_q   <= count_d == CW'(DEPTH);
        end
    end
    // storage is not reset; stale words are unreachable once the pointers clear
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end
    assign rd_data = mem[rd_ptr_q];
    assign empty   = empty_q;
    assign full    = full_q;
    assign count   = count_q;
endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: captures UART receiver words once per rdrf assertion into a FIFO with overflow tracking
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int OVF_MODE = OVF_DROP
) (
    input logic clk,
    input logic clr,
    uart_rx_fifo_ctrl_if.slave bus
);
    logic [1:0] state_q, state_d;
    logic       rdrf_clr_q, ovf_q, ovf_d;
    logic       capture, ovf_evt, fifo_rd;
    // a word is taken only on the first edge of an rdrf assertion
    assign capture = state_q == ST_WAIT && bus.rdrf;
    // a push into a full FIFO with no pop is an overflow; in overwrite mode the head is forced out to make room
    assign ovf_evt = capture && bus.full && !bus.rd_en;
    assign fifo_rd = (bus.rd_en && !bus.empty) || (ovf_evt && OVF_MODE == OVF_OVERWRITE);
    // capture FSM: WAIT -> CLR on capture, then park in HOLD until rdrf drops
    always_comb begin
        state_d = state_q == ST_WAIT ? (bus.rdrf ? ST_CLR : ST_WAIT) : (bus.rdrf ? ST_HOLD : ST_WAIT);
        ovf_d   = ovf_evt || (ovf_q && !bus.ovf_clr);
    end
    // state, clear pulse and sticky overflow registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_WAIT;
            rdrf_clr_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdrf_clr_q <= capture;
            ovf_q      <= ovf_d;
        end
    end
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .wr_en   (capture),
        .wr_data (bus.rx_data),
        .rd_en   (fifo_rd),
        .rd_data (bus.dout),
        .empty   (bus.empty),
        .full    (bus.full),
        .count   (bus.count)
    );
    assign bus.rdrf_clr = rdrf_clr_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb_uart_rx_fifo_ctrl: vector table, corner sequences and randomized model check for drop and overwrite modes
module tb_uart_rx_fifo_ctrl;
    logic clk, clr;
    int tests = 0, fails = 0;
    uart_rx_fifo_ctrl_if #(.DATA_W(8), .DEPTH(4)) b0 ();
    uart_rx_fifo_ctrl_if #(.DATA_W(8), .DEPTH(4)) b1 ();
    uart_rx_fifo_ctrl #(.DATA_W(8), .DEPTH(4), .OVF_MODE(0)) dut0 (.clk(clk), .clr(clr), .bus(b0));
    uart_rx_fifo_ctrl #(.DATA_W(8), .DEPTH(4), .OVF_MODE(1)) dut1 (.clk(clk), .clr(clr), .bus(b1));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic rdrf; logic [7:0] rx; logic rd; logic oc; logic eclr;
        int c0; logic [7:0] d0; logic v0;
        int c1; logic [7:0] d1; logic v1;
    } vec_t;

    function automatic vec_t mk(logic r, logic [7:0] x, logic rd, logic oc, logic e,
                                int c0, logic [7:0] d0, logic v0, int c1, logic [7:0] d1, logic v1);
        vec_t v;
        v.rdrf = r; v.rx = x; v.rd = rd; v.oc = oc; v.eclr = e;
        v.c0 = c0; v.d0 = d0; v.v0 = v0; v.c1 = c1; v.d1 = d1; v.v1 = v1;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] x, input logic rd, input logic oc);
        b0.rdrf = r; b0.rx_data = x; b0.rd_en = rd; b0.ovf_clr = oc;
        b1.rdrf = r; b1.rx_data = x; b1.rd_en = rd; b1.ovf_clr = oc;
    endtask

    task automatic cmp(input int m, input logic eclr, input int ec, input logic [7:0] ed,
                       input logic ev, input string tag);
        chk($sformatf("%s m%0d rdrf_clr", tag, m), int'(m ? b1.rdrf_clr : b0.rdrf_clr), int'(eclr));
        chk($sformatf("%s m%0d count", tag, m), int'(m ? b1.count : b0.count), ec);
        chk($sformatf("%s m%0d empty", tag, m), int'(m ? b1.empty : b0.empty), int'(ec == 0));
        chk($sformatf("%s m%0d full", tag, m), int'(m ? b1.full : b0.full), int'(ec == 4));
        chk($sformatf("%s m%0d ovf", tag, m), int'(m ? b1.ovf : b0.ovf), int'(ev));
        if (ec != 0)
            chk($sformatf("%s m%0d dout", tag, m), int'(m ? b1.dout : b0.dout), int'(ed));
    endtask

    // reference model: per-mode word list, sticky overflow, and a shared "waiting for rdrf low" flag
    logic [7:0] mq [2][4];
    int         mn [2];
    logic       mo [2];
    logic       blocked;

    task automatic model_reset();
        mn[0] = 0; mn[1] = 0; mo[0] = 0; mo[1] = 0; blocked = 0;
    endtask

    task automatic model_step(input logic r, input logic [7:0] x, input logic rd, input logic oc,
                              output logic cap);
        cap = r && !blocked;
        for (int m = 0; m < 2; m++) begin
            int  n;
            logic pop;
            n = mn[m];
            pop = rd && n > 0;
            if (oc) mo[m] = 0;
            if (pop) begin
                for (int k = 0; k < 3; k++) mq[m][k] = mq[m][k+1];
                n--;
            end
            if (cap) begin
                if (mn[m] < 4 || pop) begin
                    mq[m][n] = x; n++;
                end else begin
                    mo[m] = 1;
                    if (m == 1) begin
                        for (int k = 0; k < 3; k++) mq[m][k] = mq[m][k+1];
                        mq[m][3] = x;
                    end
                end
            end
            mn[m] = n;
        end
        if (cap) blocked = 1;
        else if (!r) blocked = 0;
    endtask

    vec_t tbl [32];

    initial begin
        logic cap;
        logic r, rd, oc;
        logic [7:0] x;
        tbl[0]  = mk(1, 8'hA5, 0, 0, 1, 1, 8'hA5, 0, 1, 8'hA5, 0);
        tbl[1]  = mk(0, 8'h00, 0, 0, 0, 1, 8'hA5, 0, 1, 8'hA5, 0);
        tbl[2]  = mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        tbl[3]  = mk(1, 8'h3C, 0, 0, 1, 1, 8'h3C, 0, 1, 8'h3C, 0);
        tbl[4]  = mk(1, 8'h3C, 0, 0, 0, 1, 8'h3C, 0, 1, 8'h3C, 0);
        tbl[5]  = mk(1, 8'h3C, 0, 0, 0, 1, 8'h3C, 0, 1, 8'h3C, 0);
        tbl[6]  = mk(1, 8'h3C, 0, 0, 0, 1, 8'h3C, 0, 1, 8'h3C, 0);
        tbl[7]  = mk(1, 8'h3C, 0, 0, 0, 1, 8'h3C, 0, 1, 8'h3C, 0);
        tbl[8]  = mk(0, 8'h00, 0, 0, 0, 1, 8'h3C, 0, 1, 8'h3C, 0);
        tbl[9]  = mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        tbl[10] = mk(1, 8'h01, 0, 0, 1, 1, 8'h01, 0, 1, 8'h01, 0);
        tbl[11] = mk(0, 8'h00, 0, 0, 0, 1, 8'h01, 0, 1, 8'h01, 0);
        tbl[12] = mk(1, 8'h02, 0, 0, 1, 2, 8'h01, 0, 2, 8'h01, 0);
        tbl[13] = mk(0, 8'h00, 0, 0, 0, 2, 8'h01, 0, 2, 8'h01, 0);
        tbl[14] = mk(1, 8'h03, 0, 0, 1, 3, 8'h01, 0, 3, 8'h01, 0);
        tbl[15] = mk(0, 8'h00, 0, 0, 0, 3, 8'h01, 0, 3, 8'h01, 0);
        tbl[16] = mk(1, 8'h04, 0, 0, 1, 4, 8'h01, 0, 4, 8'h01, 0);
        tbl[17] = mk(0, 8'h00, 0, 0, 0, 4, 8'h01, 0, 4, 8'h01, 0);
        tbl[18] = mk(1, 8'h05, 0, 0, 1, 4, 8'h01, 1, 4, 8'h02, 1);
        tbl[19] = mk(0, 8'h00, 0, 0, 0, 4, 8'h01, 1, 4, 8'h02, 1);
        tbl[20] = mk(0, 8'h00, 0, 1, 0, 4, 8'h01, 0, 4, 8'h02, 0);
        tbl[21] = mk(1, 8'h06, 1, 0, 1, 4, 8'h02, 0, 4, 8'h03, 0);
        tbl[22] = mk(0, 8'h00, 0, 0, 0, 4, 8'h02, 0, 4, 8'h03, 0);
        tbl[23] = mk(1, 8'h07, 0, 1, 1, 4, 8'h02, 1, 4, 8'h04, 1);
        tbl[24] = mk(0, 8'h00, 0, 0, 0, 4, 8'h02, 1, 4, 8'h04, 1);
        tbl[25] = mk(0, 8'h00, 1, 0, 0, 3, 8'h03, 1, 3, 8'h05, 1);
        tbl[26] = mk(0, 8'h00, 1, 0, 0, 2, 8'h04, 1, 2, 8'h06, 1);
        tbl[27] = mk(0, 8'h00, 1, 0, 0, 1, 8'h06, 1, 1, 8'h07, 1);
        tbl[28] = mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 8'h00, 1);
        tbl[29] = mk(0, 8'h00, 1, 0, 0, 0, 8'h00, 1, 0, 8'h00, 1);
        tbl[30] = mk(1, 8'h08, 1, 0, 1, 1, 8'h08, 1, 1, 8'h08, 1);
        tbl[31] = mk(0, 8'h00, 0, 1, 0, 1, 8'h08, 0, 1, 8'h08, 0);

        drive(0, 8'h00, 0, 0);
        clr = 1;
        #3;
        cmp(0, 0, 0, 8'h00, 0, "reset");
        cmp(1, 0, 0, 8'h00, 0, "reset");
        @(negedge clk);
        clr = 0;

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(tbl[i].rdrf, tbl[i].rx, tbl[i].rd, tbl[i].oc);
            @(posedge clk);
            #1;
            cmp(0, tbl[i].eclr, tbl[i].c0, tbl[i].d0, tbl[i].v0, $sformatf("vec%0d", i));
            cmp(1, tbl[i].eclr, tbl[i].c1, tbl[i].d1, tbl[i].v1, $sformatf("vec%0d", i));
        end

        // clear asserted while the FSM sits in CLR must act without a clock edge
        @(negedge clk);
        drive(1, 8'hAA, 0, 0);
        @(posedge clk);
        #1;
        cmp(0, 1, 2, 8'h08, 0, "capture_before_clr");
        #1;
        clr = 1;
        #1;
        cmp(0, 0, 0, 8'h00, 0, "async_clr");
        cmp(1, 0, 0, 8'h00, 0, "async_clr");

        // rdrf already high when clear releases: first edge captures
        drive(1, 8'h5A, 0, 0);
        @(negedge clk);
        clr = 0;
        @(posedge clk);
        #1;
        cmp(0, 1, 1, 8'h5A, 0, "post_clr_capture");
        cmp(1, 1, 1, 8'h5A, 0, "post_clr_capture");
        @(negedge clk);
        drive(0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        cmp(0, 0, 1, 8'h5A, 0, "post_clr_hold");

        @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            r  = 1'($urandom_range(0, 1));
            x  = 8'($urandom);
            rd = (i < 1500) ? ($urandom_range(0, 99) < 15) : ($urandom_range(0, 99) < 50);
            oc = $urandom_range(0, 19) == 0;
            drive(r, x, rd, oc);
            @(posedge clk);
            #1;
            model_step(r, x, rd, oc, cap);
            cmp(0, cap, mn[0], mq[0][0], mo[0], $sformatf("rnd%0d", i));
            cmp(1, cap, mn[1], mq[1][0], mo[1], $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
